// File: rtl/rep3_serial_tx.sv
// rep3_serial_tx: serial transmitter that sends every symbol as three identical chips (3x repetition code).
// Define REP3_PARITY_EN to insert an even-parity symbol between the last data symbol and the stop symbol.
module rep3_serial_tx #(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              tx,
    output logic              busy
);

    // Counter widths cover the largest legal parameters (16 data bits, 65535 clocks per chip).
    localparam int               SYM_W     = 5;
    localparam logic [15:0]      LAST_CYC  = 16'(BIT_CYCLES - 1);
    localparam logic [SYM_W-1:0] LAST_SYM  = SYM_W'(DATA_W - 1);
    localparam logic [1:0]       LAST_CHIP = 2'd2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef REP3_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         cyc_q, cyc_d;
    logic [1:0]          chip_q, chip_d;
    logic [SYM_W-1:0]    sym_q, sym_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   data_shift;
    logic                tx_q, tx_d;
    logic                chip_done;
    logic                sym_done;

    assign chip_done = (cyc_q == LAST_CYC);
    assign sym_done  = chip_done && (chip_q == LAST_CHIP);

    // NOTE: every next-state variable gets its hold value first, so no path through the
    // case statements can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        chip_d  = chip_q;
        sym_d   = sym_q;
        data_d  = data_q;

        case (state_q)
            IDLE: begin
                if (din_valid) begin
                    state_d = START;
                    data_d  = din;
                    cyc_d   = '0;
                    chip_d  = '0;
                    sym_d   = '0;
                end
            end
            default: begin
                if (!chip_done) begin
                    cyc_d = cyc_q + 16'd1;
                end else begin
                    cyc_d  = '0;
                    chip_d = sym_done ? 2'd0 : chip_q + 2'd1;
                end

                if (sym_done) begin
                    case (state_q)
                        START: begin
                            state_d = DATA;
                            sym_d   = '0;
                        end
                        DATA: begin
                            if (sym_q == LAST_SYM) begin
`ifdef REP3_PARITY_EN
                                state_d = PARITY;
`else
                                state_d = STOP;
`endif
                            end else begin
                                sym_d = sym_q + SYM_W'(1);
                            end
                        end
`ifdef REP3_PARITY_EN
                        PARITY: state_d = STOP;
`endif
                        default: state_d = IDLE;
                    endcase
                end
            end
        endcase
    end

    // The line value is computed from the next state so the registered tx lines up with it:
    // the first start chip appears the clock after acceptance.
    always_comb begin
        data_shift = data_d >> sym_d;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_shift[0];
`ifdef REP3_PARITY_EN
            PARITY:  tx_d = ^data_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            chip_q  <= '0;
            sym_q   <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            chip_q  <= chip_d;
            sym_q   <= sym_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
        end
    end

    assign tx        = tx_q;
    assign busy      = (state_q != IDLE);
    assign din_ready = (state_q == IDLE);

endmodule

// File: tb/tb_rep3_serial_tx.sv
// Self-checking bench for rep3_serial_tx: table vectors, multi-cycle corner sequences and
// randomized loopback through a 2-of-3 majority voter, all against a symbol-level model.
module tb_rep3_serial_tx;

`ifdef REP3_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NSYM = 8 + 2 + P;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din_a, din_b;
    logic       valid_a, valid_b;
    logic       ready_a, ready_b;
    logic       tx_a, tx_b;
    logic       busy_a, busy_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic exp_q[$];
    logic cap[$];

    always #5 clk = ~clk;

    rep3_serial_tx #(.DATA_W(8), .BIT_CYCLES(1)) u_dut_a (
        .clk(clk), .rst(rst), .din(din_a), .din_valid(valid_a),
        .din_ready(ready_a), .tx(tx_a), .busy(busy_a)
    );

    rep3_serial_tx #(.DATA_W(8), .BIT_CYCLES(4)) u_dut_b (
        .clk(clk), .rst(rst), .din(din_b), .din_valid(valid_b),
        .din_ready(ready_b), .tx(tx_b), .busy(busy_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic get_tx(input int which);
        return (which == 0) ? tx_a : tx_b;
    endfunction

    function automatic logic get_busy(input int which);
        return (which == 0) ? busy_a : busy_b;
    endfunction

    function automatic logic get_ready(input int which);
        return (which == 0) ? ready_a : ready_b;
    endfunction

    task automatic drive(input int which, input logic [7:0] v, input logic valid);
        if (which == 0) begin
            din_a   = v;
            valid_a = valid;
        end else begin
            din_b   = v;
            valid_b = valid;
        end
    endtask

    // Expected chip stream: start 0, data LSB first, optional even parity, stop 1;
    // each symbol sent 3 times, each chip held bc clocks.
    function automatic void build_exp(input logic [7:0] v, input int bc);
        logic syms[$];
        exp_q.delete();
        syms.push_back(1'b0);
        for (int b = 0; b < 8; b++) syms.push_back(v[b]);
`ifdef REP3_PARITY_EN
        syms.push_back(^v);
`endif
        syms.push_back(1'b1);
        foreach (syms[s])
            for (int r = 0; r < 3 * bc; r++) exp_q.push_back(syms[s]);
    endfunction

    // Present a word at a falling edge and let the next rising edge accept it.
    task automatic accept(input int which, input logic [7:0] v, input bit hold);
        int waited = 0;
        @(negedge clk);
        while (!get_ready(which) && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        check("ready before accept", 32'(get_ready(which)), 32'd1);
        drive(which, v, 1'b1);
        @(posedge clk);
        #1;
        if (!hold) drive(which, ~v, 1'b0);
    endtask

    // Capture tx on every falling edge while busy, then compare with the model.
    task automatic check_frame(input int which, input logic [7:0] v, input string name);
        int bc;
        int errs = 0;
        bc = (which == 0) ? 1 : 4;
        build_exp(v, bc);
        cap.delete();
        @(negedge clk);
        while (get_busy(which) && cap.size() < 1000) begin
            cap.push_back(get_tx(which));
            @(negedge clk);
        end
        check({name, " frame clocks"}, 32'(cap.size()), 32'(exp_q.size()));
        for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
            if (cap[i] !== exp_q[i]) errs++;
        check({name, " chips wrong"}, 32'(errs), 32'd0);
        check({name, " idle tx"}, 32'(get_tx(which)), 32'd1);
        check({name, " idle ready"}, 32'(get_ready(which)), 32'd1);
    endtask

    typedef struct {
        logic [7:0] din;
        int         exp_clocks;
        logic       exp_par;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [29:0] pat;
        logic [29:0] got;
        logic [7:0]  v;
        logic [7:0]  dec;
        logic        ch[0:32];
        int          k;
        int          votes;

        vecs[0] = '{8'hA5, NSYM * 3, 1'b0};
        vecs[1] = '{8'h07, NSYM * 3, 1'b1};
        vecs[2] = '{8'h03, NSYM * 3, 1'b0};
        vecs[3] = '{8'h00, NSYM * 3, 1'b0};
        vecs[4] = '{8'h80, NSYM * 3, 1'b1};

        // Reset state, checked before any clock edge and again after a few clocks.
        rst = 1'b1;
        drive(0, 8'h00, 1'b0);
        drive(1, 8'h00, 1'b0);
        #1;
        check("reset tx", 32'(tx_a), 32'd1);
        check("reset busy", 32'(busy_a), 32'd0);
        check("reset ready", 32'(ready_a), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("reset hold tx", 32'(tx_b), 32'd1);
        check("reset hold busy", 32'(busy_b), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table vectors on the BIT_CYCLES=1 instance.
        for (int t = 0; t < 5; t++) begin
            accept(0, vecs[t].din, 1'b0);
            check_frame(0, vecs[t].din, $sformatf("vec %02h", vecs[t].din));
            check($sformatf("vec %02h table clocks", vecs[t].din), 32'(cap.size()), 32'(vecs[t].exp_clocks));
`ifdef REP3_PARITY_EN
            if (cap.size() > 29)
                check($sformatf("vec %02h parity chips", vecs[t].din),
                      32'({cap[27], cap[28], cap[29]}), 32'({3{vecs[t].exp_par}}));
`else
            if (vecs[t].din == 8'hA5 && cap.size() >= 30) begin
                pat = 30'b000111000111000000111000111111;
                for (int i = 0; i < 30; i++) got[29-i] = cap[i];
                check("A5 literal pattern", 32'(got), 32'(pat));
            end
`endif
        end

        // Each chip held 4 clocks.
        accept(1, 8'h01, 1'b0);
        check_frame(1, 8'h01, "bc4 01");
        check("bc4 01 table clocks", 32'(cap.size()), 32'(NSYM * 12));

        // Back-to-back frames with din_valid held high and din changing mid-frame.
        accept(0, 8'h55, 1'b1);
        drive(0, 8'hAA, 1'b1);
        check_frame(0, 8'h55, "b2b first");
        @(posedge clk);
        #1;
        drive(0, 8'h3C, 1'b0);
        check("b2b single idle clock", 32'(busy_a), 32'd1);
        check_frame(0, 8'hAA, "b2b second");

        // Reset at clock 12 of a 0xFF frame, then a clean frame on the first edge after release.
        accept(0, 8'hFF, 1'b0);
        repeat (11) @(posedge clk);
        #3;
        check("pre-abort busy", 32'(busy_a), 32'd1);
        rst = 1'b1;
        #1;
        check("abort tx", 32'(tx_a), 32'd1);
        check("abort busy", 32'(busy_a), 32'd0);
        check("abort ready", 32'(ready_a), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 8'h00, 1'b1);
        @(posedge clk);
        #1;
        drive(0, 8'h5A, 1'b0);
        check("post-reset accept busy", 32'(busy_a), 32'd1);
        check_frame(0, 8'h00, "post-reset 00");

        // Random loopback: flip one chip per symbol, majority-vote, decode.
        for (int n = 0; n < 256; n++) begin
            v = 8'($urandom);
            accept(0, v, 1'b0);
            check_frame(0, v, "loopback frame");
            for (int i = 0; i < 33; i++) ch[i] = (i < cap.size()) ? cap[i] : 1'bx;
            for (int s = 0; s < NSYM; s++) begin
                k = $urandom_range(0, 2);
                ch[3*s+k] = ~ch[3*s+k];
            end
            for (int b = 0; b < 8; b++) begin
                votes = int'(ch[3*(b+1)]) + int'(ch[3*(b+1)+1]) + int'(ch[3*(b+1)+2]);
                dec[b] = (votes >= 2);
            end
            check("loopback word", 32'(dec), 32'(v));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
